fp16_anneal_sched: RTL and testbench

FP16_ANNEAL_SCHED -- requirements
Module: fp16_anneal_sched

---
 rtl/fp16_anneal_sched_if.sv | 35 +++
 rtl/fp16_anneal_sched.sv | 120 ++++++++++++
 tb/tb_fp16_anneal_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_anneal_sched_if.sv
// Handshake/bus bundle between the annealing scheduler and its
// environment: control, sweep core handshake, incrementer and status.
interface fp16_anneal_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SWEEP_W    = 8
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] t_init;
  logic [DATA_WIDTH-1:0] t_final;
  logic [SWEEP_W-1:0]    sweeps_per_step;
  logic                  sweep_go;
  logic                  sweep_done;
  logic                  en_incr;
  logic [DATA_WIDTH-1:0] val;
  logic [DATA_WIDTH-1:0] res;
  logic [DATA_WIDTH-1:0] beta;
  logic                  busy;
  logic                  done;
  logic [7:0]            levels;

  modport slave (
    input  start, abort, t_init, t_final,
    input  sweeps_per_step, sweep_done, res,
    output sweep_go, en_incr, val, beta,
    output busy, done, levels
  );

  modport master (
    output start, abort, t_init, t_final,
    output sweeps_per_step, sweep_done, res,
    input  sweep_go, en_incr, val, beta,
    input  busy, done, levels
  );
endinterface

// File: rtl/fp16_anneal_sched.sv
// FP16 beta annealing scheduler: runs N sweeps per beta level, then
// steps beta through an external FP16 incrementer until t_final.
// Ports: clk, reset (async, active-high), bus (slave modport).
module fp16_anneal_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int SWEEP_W    = 8
) (
  input logic                clk,
  input logic                reset,
  fp16_anneal_sched_if.slave bus
);
  localparam int MW = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] BETA_MAX =
    DATA_WIDTH'(16'h7BFF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SWEEP,
    S_CHECK,
    S_INCR,
    S_WAIT_INC,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] beta_q, beta_d;
  logic [MW-1:0]         tf_q, tf_d;
  logic [SWEEP_W-1:0]    spp_q, spp_d;
  logic [SWEEP_W-1:0]    cnt_q, cnt_d;
  logic [7:0]            levels_q, levels_d;
  logic                  sat_q, sat_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      beta_q   <= '0;
      tf_q     <= '0;
      spp_q    <= '0;
      cnt_q    <= '0;
      levels_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beta_q   <= beta_d;
      tf_q     <= tf_d;
      spp_q    <= spp_d;
      cnt_q    <= cnt_d;
      levels_q <= levels_d;
      sat_q    <= sat_d;
    end
  end

  // Abort overrides everything; beta and levels stay as they were.
  always_comb begin
    state_d  = state_q;
    beta_d   = beta_q;
    tf_d     = tf_q;
    spp_d    = spp_q;
    cnt_d    = cnt_q;
    levels_d = levels_q;
    sat_d    = sat_q;
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            tf_d     = bus.t_final[MW-1:0];
            // zero sweeps would never finish a level
            spp_d    = (bus.sweeps_per_step == '0) ?
                       SWEEP_W'(1) : bus.sweeps_per_step;
            beta_d   = {1'b0, bus.t_init[MW-1:0]};
            cnt_d    = '0;
            levels_d = '0;
            sat_d    = 1'b0;
            state_d  = S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_WAIT_SWEEP;
        S_WAIT_SWEEP: begin
          if (bus.sweep_done) begin
            cnt_d   = cnt_q + SWEEP_W'(1);
            state_d = (cnt_d < spp_q) ? S_ISSUE : S_CHECK;
          end
        end
        S_CHECK: begin
          levels_d = levels_q +
                     {7'd0, levels_q != 8'hFF};
          if (beta_q[MW-1:0] >= tf_q ||
              beta_q == BETA_MAX || sat_q)
            state_d = S_DONE;
          else
            state_d = S_INCR;
        end
        S_INCR: state_d = S_WAIT_INC;
        S_WAIT_INC: begin
          beta_d  = bus.res;
          cnt_d   = '0;
          // a non-increasing result means the incrementer clipped
          sat_d   = bus.res[MW-1:0] <= beta_q[MW-1:0];
          state_d = S_ISSUE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pulses are masked during the abort cycle.
  always_comb begin
    bus.sweep_go = (state_q == S_ISSUE) && !bus.abort;
    bus.en_incr  = (state_q == S_INCR) && !bus.abort;
    bus.done     = (state_q == S_DONE) && !bus.abort;
    bus.busy     = (state_q != S_IDLE);
    bus.val      = beta_q;
    bus.beta     = beta_q;
    bus.levels   = levels_q;
  end
endmodule

// File: tb/tb_fp16_anneal_sched.sv
// Randomized bench for fp16_anneal_sched against a level-by-level
// reference model, with directed basic/abort/saturation/reset runs.
module tb_fp16_anneal_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp16_anneal_sched_if #(.DATA_WIDTH(16), .SWEEP_W(8)) bus ();

  fp16_anneal_sched #(.DATA_WIDTH(16), .SWEEP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_go, n_inc, n_done;
  logic [15:0] got_vals[$];
  logic [15:0] exp_vals[$];
  int inc_mode = 0;
  int core_dly = 3;
  logic start_r = 1'b0;
  logic spur_en = 1'b0;
  int sd_cnt;
  logic sd_core, sd_q1;

  function automatic logic [15:0] incr_f(
    input logic [15:0] v, input int mode);
    logic [16:0] s;
    if (mode == 1) return v;
    s = {1'b0, v} + 17'h0400;
    if (s > 17'h07BFF) return 16'h7BFF;
    return s[15:0];
  endfunction

  always @(posedge clk)
    if (bus.en_incr) bus.res <= incr_f(bus.val, inc_mode);

  always @(posedge clk or posedge reset)
    if (reset) sd_cnt <= 0;
    else if (bus.sweep_go) sd_cnt <= core_dly;
    else if (sd_cnt != 0) sd_cnt <= sd_cnt - 1;

  assign sd_core = (sd_cnt == 1);

  always @(posedge clk) sd_q1 <= sd_core;

  assign bus.sweep_done = sd_core |
    (spur_en & (sd_q1 | ~bus.busy));
  assign bus.start = start_r |
    (spur_en & (bus.sweep_go | bus.en_incr));

  always @(negedge clk)
    if (!reset) begin
      if (bus.sweep_go) n_go++;
      if (bus.en_incr) begin
        n_inc++;
        got_vals.push_back(bus.val);
      end
      if (bus.done) n_done++;
    end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model(input logic [15:0] ti, tf,
                       input logic [7:0] spp, input int mode,
                       output int eg, ei, el,
                       output logic [15:0] eb);
    logic [15:0] b, nb;
    bit sat;
    int per;
    per = (spp == 0) ? 1 : int'(spp);
    b = {1'b0, ti[14:0]};
    eg = 0; ei = 0; el = 0; sat = 0;
    exp_vals.delete();
    while (1) begin
      eg += per;
      if (el < 255) el++;
      if (b[14:0] >= tf[14:0] || b == 16'h7BFF || sat) break;
      ei++;
      exp_vals.push_back(b);
      nb = incr_f(b, mode);
      sat = (nb[14:0] <= b[14:0]);
      b = nb;
    end
    eb = b;
  endtask

  task automatic kick(input logic [15:0] ti, tf,
                      input logic [7:0] spp,
                      input int mode, input int dly);
    inc_mode = mode;
    core_dly = dly;
    @(posedge clk); #1;
    n_go = 0; n_inc = 0; n_done = 0;
    got_vals.delete();
    bus.t_init = ti;
    bus.t_final = tf;
    bus.sweeps_per_step = spp;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
  endtask

  task automatic run_sched(input logic [15:0] ti, tf,
                           input logic [7:0] spp,
                           input int mode, input int dly,
                           input string tag);
    int eg, ei, el;
    logic [15:0] eb;
    model(ti, tf, spp, mode, eg, ei, el, eb);
    kick(ti, tf, spp, mode, dly);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      if (n_done != 0) break;
    end
    chk({tag, "_fin"}, 32'(n_done != 0), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    chk({tag, "_go"}, n_go, eg);
    chk({tag, "_inc"}, n_inc, ei);
    for (int i = 0; i < exp_vals.size() &&
         i < got_vals.size(); i++)
      chk({tag, "_val"}, got_vals[i], exp_vals[i]);
    chk({tag, "_beta"}, bus.beta, eb);
    chk({tag, "_lvl"}, bus.levels, el);
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  logic [15:0] ti, tf;
  logic [7:0] spp;
  int g;

  initial begin
    reset = 1'b1;
    bus.abort = 1'b0;
    bus.t_init = '0;
    bus.t_final = '0;
    bus.sweeps_per_step = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_go", bus.sweep_go, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_beta", bus.beta, 0);
    chk("rst_lvl", bus.levels, 0);
    reset = 1'b0;

    run_sched(16'h3C00, 16'h4400, 8'd2, 0, 3, "basic");
    chk("basic_b", bus.beta, 16'h4400);
    chk("basic_n", n_go * 100 + n_inc * 10 + 32'(bus.levels),
        623);
    run_sched(16'h4800, 16'h4400, 8'd0, 0, 3, "single");
    run_sched(16'h7800, 16'h7C00, 8'd1, 0, 2, "sat");
    chk("sat_b", bus.beta, 16'h7BFF);
    run_sched(16'h3C00, 16'h4400, 8'd2, 1, 2, "stuck");

    kick(16'h3C00, 16'h4400, 8'd2, 0, 3);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (n_go >= 3) break;
    end
    chk("ab_reach", 32'(n_go >= 3), 1);
    bus.abort = 1'b1;
    #1;
    chk("ab_go", bus.sweep_go, 0);
    chk("ab_inc", bus.en_incr, 0);
    chk("ab_dn", bus.done, 0);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_beta", bus.beta, 16'h4000);
    repeat (8) @(posedge clk);
    #2;
    chk("ab_nodone", n_done, 0);
    run_sched(16'h3C00, 16'h4400, 8'd2, 0, 3, "rerun");

    spur_en = 1'b1;
    run_sched(16'h3C00, 16'h4400, 8'd2, 0, 3, "spur");
    spur_en = 1'b0;
    repeat (4) @(posedge clk);

    kick(16'h3C00, 16'h4400, 8'd2, 0, 3);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (n_inc >= 1) break;
    end
    chk("rs_reach", 32'(n_inc >= 1), 1);
    #1 reset = 1'b1;
    #1;
    chk("rs_go", bus.sweep_go, 0);
    chk("rs_inc", bus.en_incr, 0);
    chk("rs_busy", bus.busy, 0);
    chk("rs_done", bus.done, 0);
    chk("rs_beta", bus.beta, 0);
    chk("rs_lvl", bus.levels, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    g = n_go;
    repeat (6) @(posedge clk);
    #2;
    chk("rs_idle", bus.busy, 0);
    chk("rs_quiet", n_go, g);
    chk("rs_nodn", n_done, 0);

    for (int r = 0; r < 20; r++) begin
      ti = 16'($urandom_range(16'h7BFF, 16'h3000));
      if ($urandom_range(1, 0) == 1) ti[15] = 1'b1;
      tf = 16'($urandom_range(16'h7C00, 16'h3000));
      spp = 8'($urandom_range(3, 0));
      run_sched(ti, tf, spp,
                ($urandom_range(3, 0) == 0) ? 1 : 0,
                int'($urandom_range(4, 1)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
